// File: rtl/cdc_fifo_pkg.sv
// Shared types and helpers for the CDC FIFO input arbiter.
package cdc_fifo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotating-priority encoder: first set request at or above
// startPtr, wrapping modulo REQUESTER_COUNT.
module rr_priority_picker
  import cdc_fifo_pkg::*;
#(
  parameter int REQUESTER_COUNT = 4,
  localparam int ID_BITWIDTH = id_width(REQUESTER_COUNT)
) (
  input  logic [REQUESTER_COUNT-1:0] reqVec,
  input  logic [ID_BITWIDTH-1:0]     startPtr,
  output logic                       found,
  output logic [ID_BITWIDTH-1:0]     index
);

  int candidate;

  // Scan upward from startPtr; the wrap never produces an index >= REQUESTER_COUNT.
  always_comb begin
    found     = 1'b0;
    index     = '0;
    candidate = 0;
    for (int k = 0; k < REQUESTER_COUNT; k++) begin
      candidate = int'(startPtr) + k;
      if (candidate >= REQUESTER_COUNT) begin
        candidate = candidate - REQUESTER_COUNT;
      end
      if (!found && reqVec[candidate]) begin
        found = 1'b1;
        index = ID_BITWIDTH'(candidate);
      end
    end
  end

endmodule

// File: rtl/cdc_fifo_input_arbiter.sv
// Round-robin arbiter sharing the write port of a CDC FIFO between several
// producers. Each accepted word is tagged with its source index.
//
// state | meaning
// IDLE  | no producer holds the port, arbitrate from pointer
// GRANT | grant owns the port, up to MAX_BURST transfers
module cdc_fifo_input_arbiter
  import cdc_fifo_pkg::*;
#(
  parameter int REQUESTER_COUNT = 4,
  parameter int DATA_BITWIDTH   = 8,
  parameter int MAX_BURST       = 4,
  localparam int ID_BITWIDTH    = id_width(REQUESTER_COUNT)
) (
  input  logic                                     clk,
  input  logic                                     async_rst,
  input  logic [REQUESTER_COUNT-1:0]               ReqREQ,
  output logic [REQUESTER_COUNT-1:0]               ReqACK,
  input  logic [REQUESTER_COUNT*DATA_BITWIDTH-1:0] ReqData,
  output logic                                     FifoREQ,
  input  logic                                     FifoACK,
  output logic [ID_BITWIDTH+DATA_BITWIDTH-1:0]     FifoData,
  output logic                                     GrantValid,
  output logic [ID_BITWIDTH-1:0]                   CurrentGrant
);

  localparam int BURST_BITWIDTH = $clog2(MAX_BURST + 1);
  localparam logic [BURST_BITWIDTH-1:0] LAST_BEAT = BURST_BITWIDTH'(MAX_BURST - 1);
  localparam logic [ID_BITWIDTH-1:0]    LAST_ID   = ID_BITWIDTH'(REQUESTER_COUNT - 1);

  arb_state_t                state;
  logic [ID_BITWIDTH-1:0]    grant;
  logic [ID_BITWIDTH-1:0]    pointer;
  logic [BURST_BITWIDTH-1:0] burstCount;

  logic [DATA_BITWIDTH-1:0]  reqWord [REQUESTER_COUNT];
  logic [ID_BITWIDTH-1:0]    nextPointer;
  logic                      transfer;
  logic                      releaseGrant;
  logic                      idleFound;
  logic [ID_BITWIDTH-1:0]    idleIndex;
  logic                      relFound;
  logic [ID_BITWIDTH-1:0]    relIndex;

  // Split the packed payload bus into per-producer words.
  always_comb begin
    for (int i = 0; i < REQUESTER_COUNT; i++) begin
      reqWord[i] = ReqData[i*DATA_BITWIDTH +: DATA_BITWIDTH];
    end
  end

  // Port muxing toward the FIFO; FifoACK reaches ReqACK without a register.
  always_comb begin
    FifoREQ  = 1'b0;
    FifoData = '0;
    ReqACK   = '0;
    if (state == GRANT) begin
      FifoREQ       = ReqREQ[grant];
      FifoData      = {grant, reqWord[grant]};
      ReqACK[grant] = FifoACK && ReqREQ[grant];
    end
  end

  assign transfer     = FifoREQ && FifoACK;
  assign releaseGrant = (state == GRANT) &&
                        (!ReqREQ[grant] || (transfer && (burstCount == LAST_BEAT)));
  assign nextPointer  = (grant == LAST_ID) ? '0 : grant + 1'b1;

  assign GrantValid   = (state == GRANT);
  assign CurrentGrant = grant;

  rr_priority_picker #(
    .REQUESTER_COUNT(REQUESTER_COUNT)
  ) idlePicker (
    .reqVec  (ReqREQ),
    .startPtr(pointer),
    .found   (idleFound),
    .index   (idleIndex)
  );

  // Release re-arbitration starts just past the outgoing grant, so that
  // producer drops to lowest priority without losing eligibility.
  rr_priority_picker #(
    .REQUESTER_COUNT(REQUESTER_COUNT)
  ) releasePicker (
    .reqVec  (ReqREQ),
    .startPtr(nextPointer),
    .found   (relFound),
    .index   (relIndex)
  );

  // Grant/burst state machine; a stalled FIFO holds the grant with no timeout.
  always_ff @(posedge clk or negedge async_rst) begin
    if (!async_rst) begin
      state      <= IDLE;
      grant      <= '0;
      pointer    <= '0;
      burstCount <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (idleFound) begin
            grant      <= idleIndex;
            burstCount <= '0;
            state      <= GRANT;
          end
        end
        GRANT: begin
          if (releaseGrant) begin
            pointer <= nextPointer;
            if (relFound) begin
              grant      <= relIndex;
              burstCount <= '0;
            end else begin
              state <= IDLE;
            end
          end else if (transfer) begin
            burstCount <= burstCount + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_fifo_input_arbiter.sv
// Directed bench for the FIFO input arbiter: one instance with MAX_BURST=4
// and one with MAX_BURST=1, sharing clock and reset.
module tb_cdc_fifo_input_arbiter;

  logic       clk;
  logic       async_rst;

  logic [3:0]  reqREQ;
  logic [3:0]  reqACK;
  logic [31:0] reqData;
  logic        fifoREQ;
  logic        fifoACK;
  logic [9:0]  fifoData;
  logic        grantValid;
  logic [1:0]  currentGrant;

  logic [3:0]  reqREQ1;
  logic [3:0]  reqACK1;
  logic        fifoREQ1;
  logic        fifoACK1;
  logic [9:0]  fifoData1;
  logic        grantValid1;
  logic [1:0]  currentGrant1;

  int assertCount = 0;
  int failCount   = 0;

  cdc_fifo_input_arbiter #(
    .REQUESTER_COUNT(4), .DATA_BITWIDTH(8), .MAX_BURST(4)
  ) dut (
    .clk(clk), .async_rst(async_rst),
    .ReqREQ(reqREQ), .ReqACK(reqACK), .ReqData(reqData),
    .FifoREQ(fifoREQ), .FifoACK(fifoACK), .FifoData(fifoData),
    .GrantValid(grantValid), .CurrentGrant(currentGrant)
  );

  cdc_fifo_input_arbiter #(
    .REQUESTER_COUNT(4), .DATA_BITWIDTH(8), .MAX_BURST(1)
  ) dutSingle (
    .clk(clk), .async_rst(async_rst),
    .ReqREQ(reqREQ1), .ReqACK(reqACK1), .ReqData(reqData),
    .FifoREQ(fifoREQ1), .FifoACK(fifoACK1), .FifoData(fifoData1),
    .GrantValid(grantValid1), .CurrentGrant(currentGrant1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    async_rst = 1'b0;
    reqREQ    = 4'b0000;
    reqREQ1   = 4'b0000;
    fifoACK   = 1'b0;
    fifoACK1  = 1'b0;
    stepClk();
    stepClk();
    checkValue("rst_grantValid", 32'(grantValid), 32'd0);
    checkValue("rst_currentGrant", 32'(currentGrant), 32'd0);
    checkValue("rst_fifoREQ", 32'(fifoREQ), 32'd0);
    checkValue("rst_fifoData", 32'(fifoData), 32'd0);
    checkValue("rst_reqACK", 32'(reqACK), 32'd0);
    async_rst = 1'b1;
  endtask

  initial begin
    async_rst = 1'b0;
    reqData   = {8'h33, 8'h22, 8'hA5, 8'h10};
    reqREQ    = '0;
    reqREQ1   = '0;
    fifoACK   = 1'b0;
    fifoACK1  = 1'b0;

    // Reset mid-burst, then producer 0 must win first.
    applyReset();
    reqREQ  = 4'b0010;
    fifoACK = 1'b1;
    stepClk();
    #1;
    checkValue("t1_grantValid", 32'(grantValid), 32'd1);
    checkValue("t1_currentGrant", 32'(currentGrant), 32'd1);
    checkValue("t1_reqACK", 32'(reqACK), 32'b0010);
    checkValue("t1_fifoData", 32'(fifoData), 32'h1A5);
    stepClk();
    stepClk();
    #2;
    async_rst = 1'b0;
    #1;
    checkValue("t1_rstGrantValid", 32'(grantValid), 32'd0);
    checkValue("t1_rstFifoREQ", 32'(fifoREQ), 32'd0);
    checkValue("t1_rstReqACK", 32'(reqACK), 32'd0);
    reqREQ = 4'b0011;
    stepClk();
    async_rst = 1'b1;
    stepClk();
    #1;
    checkValue("t1_firstGrant", 32'(currentGrant), 32'd0);
    checkValue("t1_firstValid", 32'(grantValid), 32'd1);

    // Round-robin fairness with every producer requesting.
    applyReset();
    reqREQ  = 4'b1111;
    fifoACK = 1'b1;
    stepClk();
    for (int i = 0; i < 17; i++) begin
      #1;
      checkValue($sformatf("t2_tag%0d", i), 32'(fifoData[9:8]), 32'((i / 4) % 4));
      checkValue($sformatf("t2_req%0d", i), 32'(fifoREQ), 32'd1);
      stepClk();
    end

    // Early release by producer 2, then pointer sits at 3.
    applyReset();
    reqREQ  = 4'b0100;
    fifoACK = 1'b1;
    stepClk();
    for (int i = 0; i < 2; i++) begin
      #1;
      checkValue($sformatf("t3_data%0d", i), 32'(fifoData), 32'h222);
      checkValue($sformatf("t3_ack%0d", i), 32'(reqACK), 32'b0100);
      stepClk();
    end
    reqREQ = 4'b0000;
    #1;
    checkValue("t3_dropFifoREQ", 32'(fifoREQ), 32'd0);
    checkValue("t3_dropReqACK", 32'(reqACK), 32'd0);
    stepClk();
    #1;
    checkValue("t3_idle", 32'(grantValid), 32'd0);
    reqREQ = 4'b1001;
    stepClk();
    #1;
    checkValue("t3_nextGrant", 32'(currentGrant), 32'd3);
    checkValue("t3_nextData", 32'(fifoData), 32'h333);

    // FIFO full stall holds the grant without burning burst credit.
    applyReset();
    reqREQ  = 4'b0010;
    fifoACK = 1'b0;
    stepClk();
    reqREQ = 4'b0011;
    for (int i = 0; i < 10; i++) begin
      #1;
      checkValue($sformatf("t4_stallReq%0d", i), 32'(fifoREQ), 32'd1);
      checkValue($sformatf("t4_stallAck%0d", i), 32'(reqACK), 32'd0);
      checkValue($sformatf("t4_stallGrant%0d", i), 32'(currentGrant), 32'd1);
      stepClk();
    end
    fifoACK = 1'b1;
    #1;
    checkValue("t4_resumeAck", 32'(reqACK), 32'b0010);
    checkValue("t4_resumeData", 32'(fifoData), 32'h1A5);
    for (int i = 0; i < 4; i++) begin
      #1;
      checkValue($sformatf("t4_burstTag%0d", i), 32'(fifoData[9:8]), 32'd1);
      stepClk();
    end
    #1;
    checkValue("t4_afterBurst", 32'(currentGrant), 32'd0);

    // Sole requester is regranted without a bubble.
    applyReset();
    reqREQ  = 4'b1000;
    fifoACK = 1'b1;
    stepClk();
    for (int i = 0; i < 9; i++) begin
      #1;
      checkValue($sformatf("t5_valid%0d", i), 32'(grantValid), 32'd1);
      checkValue($sformatf("t5_grant%0d", i), 32'(currentGrant), 32'd3);
      checkValue($sformatf("t5_ack%0d", i), 32'(reqACK), 32'b1000);
      stepClk();
    end
    reqREQ = 4'b0000;

    // MAX_BURST=1 alternates per word.
    applyReset();
    reqREQ1  = 4'b0101;
    fifoACK1 = 1'b1;
    stepClk();
    for (int i = 0; i < 8; i++) begin
      #1;
      checkValue($sformatf("t6_tag%0d", i), 32'(fifoData1[9:8]), 32'((i % 2) * 2));
      checkValue($sformatf("t6_ack%0d", i), 32'(reqACK1), 32'(4'b0001 << ((i % 2) * 2)));
      checkValue($sformatf("t6_ackVsGrant%0d", i), 32'(reqACK1), 32'(4'b0001 << currentGrant1));
      stepClk();
    end
    reqREQ1 = 4'b0000;

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
